// File: rtl/dram_slot_arbiter.sv
// DRAM slot arbiter: VID > CPU > DMA, one owner per DRAM cycle.
// Optional DMA starvation guard enabled by defining ARB_DMA_STARVE_EN.
module dram_slot_arbiter #(
  parameter logic [3:0] DMA_STARVE_MAX = 4'd7
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        dram_cbeg,
  input  logic        dram_rrdy,
  input  logic [15:0] dram_rdata,
  output logic        dram_req,
  output logic        dram_rnw,
  output logic [20:0] dram_addr,
  output logic [1:0]  dram_bsel,
  output logic [15:0] dram_wdata,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic        vid_rstb,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_page,
  input  logic        cpu_romnram,
  input  logic [13:0] cpu_a,
  input  logic [7:0]  cpu_wd,
  output logic        cpu_wgnt,
  output logic        cpu_rstb,
  output logic [7:0]  cpu_rd,
  input  logic        dma_req,
  input  logic        dma_rnw,
  input  logic [20:0] dma_addr,
  input  logic [15:0] dma_wd,
  output logic        dma_wgnt,
  output logic        dma_rstb,
  output logic [15:0] rdata
);

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_VID_RD,
    OWN_CPU_RD,
    OWN_DMA_RD,
    OWN_CPU_WR,
    OWN_DMA_WR
  } own_e;

  own_e own_q;
  logic cpu_hi_q;
  logic cpu_dram;
  logic dma_boost;
  logic g_vid, g_cpu, g_dma;

  always_comb begin
    cpu_dram = cpu_req & ~cpu_romnram;
    g_vid    = vid_req;
    g_dma    = ~vid_req & dma_req & (~cpu_dram | dma_boost);
    g_cpu    = ~vid_req & cpu_dram & ~g_dma;
  end

`ifdef ARB_DMA_STARVE_EN
  logic [3:0] starve_q, starve_d;

  always_comb begin
    dma_boost = (starve_q >= DMA_STARVE_MAX);
    starve_d  = starve_q;
    if (!dma_req || g_dma)
      starve_d = '0;
    else if (g_cpu)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n)
      starve_q <= '0;
    else if (dram_cbeg)
      starve_q <= starve_d;
  end
`else
  logic unused_starve;
  assign dma_boost     = 1'b0;
  assign unused_starve = ^DMA_STARVE_MAX;
`endif

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      own_q      <= OWN_NONE;
      cpu_hi_q   <= 1'b0;
      dram_req   <= 1'b0;
      dram_rnw   <= 1'b0;
      dram_addr  <= '0;
      dram_bsel  <= '0;
      dram_wdata <= '0;
      vid_rstb   <= 1'b0;
      cpu_wgnt   <= 1'b0;
      cpu_rstb   <= 1'b0;
      cpu_rd     <= '0;
      dma_wgnt   <= 1'b0;
      dma_rstb   <= 1'b0;
      rdata      <= '0;
    end else begin
      vid_rstb <= 1'b0;
      cpu_rstb <= 1'b0;
      dma_rstb <= 1'b0;
      cpu_wgnt <= 1'b0;
      dma_wgnt <= 1'b0;
      if (dram_rrdy) begin
        unique case (own_q)
          OWN_VID_RD: begin
            rdata    <= dram_rdata;
            vid_rstb <= 1'b1;
            own_q    <= OWN_NONE;
          end
          OWN_DMA_RD: begin
            rdata    <= dram_rdata;
            dma_rstb <= 1'b1;
            own_q    <= OWN_NONE;
          end
          OWN_CPU_RD: begin
            cpu_rd   <= cpu_hi_q ? dram_rdata[15:8]
                                 : dram_rdata[7:0];
            cpu_rstb <= 1'b1;
            own_q    <= OWN_NONE;
          end
          default: ;
        endcase
      end
      // new slot owner overrides whatever completion did above
      if (dram_cbeg) begin
        dram_req   <= g_vid | g_cpu | g_dma;
        dram_rnw   <= 1'b0;
        dram_addr  <= '0;
        dram_bsel  <= '0;
        dram_wdata <= '0;
        own_q      <= OWN_NONE;
        unique case (1'b1)
          g_vid: begin
            dram_rnw  <= 1'b1;
            dram_addr <= vid_addr;
            dram_bsel <= 2'b11;
            own_q     <= OWN_VID_RD;
          end
          g_cpu: begin
            dram_rnw   <= cpu_rnw;
            dram_addr  <= {cpu_page, cpu_a[13:1]};
            dram_bsel  <= cpu_a[0] ? 2'b10 : 2'b01;
            dram_wdata <= {cpu_wd, cpu_wd};
            cpu_hi_q   <= cpu_a[0];
            cpu_wgnt   <= ~cpu_rnw;
            own_q      <= cpu_rnw ? OWN_CPU_RD : OWN_CPU_WR;
          end
          g_dma: begin
            dram_rnw   <= dma_rnw;
            dram_addr  <= dma_addr;
            dram_bsel  <= 2'b11;
            dram_wdata <= dma_rnw ? 16'h0000 : dma_wd;
            dma_wgnt   <= ~dma_rnw;
            own_q      <= dma_rnw ? OWN_DMA_RD : OWN_DMA_WR;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
